// File: rtl/temporal_encoder_b2t.sv
// temporal_encoder_b2t: binary-to-temporal (rising-edge) encoder.
// A value v raises its line at tick v of a gamma cycle; the line stays high until RUN ends.
// Ports:
//   aclk, grst       clock, synchronous active-high reset
//   in_valid         input vector valid
//   in_ready         shadow register empty (accept = in_valid && in_ready)
//   in_values        per-channel spike times
//   enable           permits starting new gamma cycles
//   spike_lines      rising-edge temporal outputs, one per channel
//   cycle_active     high in every RUN tick
//   gamma_start      one-tick pulse at phase 0 of each gamma cycle
//   phase            current tick within the gamma cycle
module temporal_encoder_b2t #(
    parameter int NUM_CHANNELS      = 16,
    parameter int BUS_WIDTH         = 8,
    parameter int GAMMA_CYCLE_WIDTH = 16
) (
    input  logic                                  aclk,
    input  logic                                  grst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0] in_values,
    input  logic                                  enable,
    output logic [NUM_CHANNELS-1:0]               spike_lines,
    output logic                                  cycle_active,
    output logic                                  gamma_start,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0]  phase
);

    localparam int PW = $clog2(GAMMA_CYCLE_WIDTH);
    localparam logic [PW-1:0] LAST = PW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0] active_q, shadow_q;
    logic shadow_full_q;
    logic accept, load;

    // Accept only into an empty shadow; load only from a full one,
    // so the two can never happen on the same edge.
    assign accept = in_valid && !shadow_full_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                // GAP always lasts one tick; it falls back to IDLE
                // unless a new vector can start right away.
                state_d = IDLE;
                if (shadow_full_q && enable) begin
                    load    = 1'b1;
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (phase_q == LAST) begin
                    state_d = GAP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (load) begin
                active_q      <= shadow_q;
                shadow_full_q <= 1'b0;
            end else if (accept) begin
                shadow_q      <= in_values;
                shadow_full_q <= 1'b1;
            end
        end
    end

    assign in_ready     = !shadow_full_q;
    assign cycle_active = (state_q == RUN);
    assign gamma_start  = (state_q == RUN) && (phase_q == '0);
    assign phase        = phase_q;

    // Compare at value width so out-of-range values never match any phase.
    always_comb begin
        spike_lines = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            spike_lines[i] = (state_q == RUN) &&
                             (active_q[i] <= BUS_WIDTH'(phase_q));
        end
    end

endmodule

// File: doc/temporal_encoder_b2t.md
Name: temporal_encoder_b2t

Overview:
- Binary-to-temporal encoder: converts a vector of binary values into rising-edge temporal codes, one line per channel, within a gamma cycle.
- A value v drives its line high at tick v of the cycle; the line stays high until the cycle ends.
- Feeds the temporal-to-binary mux/select blocks; it is the transmit end of the same rising-edge time coding.
- One-entry input buffer (shadow register) plus an active register allow back-to-back gamma cycles.

Parameters:
- NUM_CHANNELS, 16, number of temporal output lines / input values.
- BUS_WIDTH, 8, width of each binary input value.
- GAMMA_CYCLE_WIDTH, 16, ticks per gamma cycle; must be >= 2.

Ports:
- aclk  input  1  clock.
- grst  input  1  synchronous active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  shadow register empty; accept when in_valid && in_ready.
- in_values  input  [NUM_CHANNELS-1:0][BUS_WIDTH-1:0]  per-channel spike times.
- enable  input  1  permits starting new gamma cycles.
- spike_lines  output  [NUM_CHANNELS-1:0]  rising-edge temporal outputs.
- cycle_active  output  1  high in every RUN tick.
- gamma_start  output  1  one-tick pulse at phase 0 of each gamma cycle.
- phase  output  $clog2(GAMMA_CYCLE_WIDTH)  current tick within the gamma cycle.

Behaviour:
- Reset:
  - Synchronous; evaluated on posedge aclk only.
  - Reset values: state=IDLE, shadow_full=0, active and shadow values=0, phase=0, spike_lines=0, cycle_active=0, gamma_start=0, in_ready=1.
  - grst has priority over every other event, including mid-cycle; pending shadow data is discarded.
- Output timing: all outputs derive from registers only; there is no combinational path from any input to any output.
- Input buffer:
  - in_ready = !shadow_full.
  - On accept, the shadow captures in_values and shadow_full <= 1.
  - The shadow is never overwritten while full.
- States:
  - IDLE:
    - spike_lines=0, cycle_active=0.
    - If shadow_full && enable: active <= shadow, shadow_full <= 0, phase <= 0, go to RUN.
  - RUN:
    - cycle_active=1, gamma_start=(phase==0).
    - spike_lines[i] = (active[i] <= phase), comparison done at BUS_WIDTH with phase zero-extended.
    - phase increments each tick.
    - At phase==GAMMA_CYCLE_WIDTH-1, go to GAP and set phase <= 0.
  - GAP:
    - Exactly one tick; spike_lines=0, cycle_active=0. This is the mandatory reset phase, so a value-0 channel produces a fresh rising edge in the next cycle.
    - If shadow_full && enable: load as from IDLE and go to RUN. Otherwise go to IDLE.
- Encoding rules:
  - Value 0 gives a line high for the whole RUN.
  - Value GAMMA_CYCLE_WIDTH-1 gives a line high only at the last tick.
  - Value >= GAMMA_CYCLE_WIDTH gives no spike; the line stays low for the whole cycle.
- Latency: an accept at edge E sets shadow_full. If in IDLE with enable=1, the first RUN tick (phase 0, gamma_start=1) is the cycle after edge E+1.
- Back-to-back period: GAMMA_CYCLE_WIDTH+1 ticks (RUN length plus GAP).
- Loading vs. accepting:
  - Loading consumes the shadow. in_ready is 0 in the load tick, so accept and load never coincide.
  - in_ready returns to 1 the tick after the load.
- enable:
  - Sampled only at the IDLE/GAP decision.
  - Deasserting enable mid-RUN does not truncate the cycle; the RUN completes, then GAP, then IDLE.
- Input validity: in_values is ignored when it is not being accepted.

Test Plan:
- Reset: hold grst 2 ticks with in_valid=1 -> in_ready=1, spike_lines=0, cycle_active=0, phase=0, nothing accepted.
- Single vector, GAMMA_CYCLE_WIDTH=16, enable=1, values ch0=0, ch1=5, ch2=15, ch3=16, ch4=255, rest=3:
  - gamma_start is seen one tick after the shadow fills.
  - ch0 is high at phases 0-15; ch1 rises at phase 5; ch2 is high only at phase 15; ch3 and ch4 stay low; ch5-15 rise at phase 3.
  - All lines are low in GAP, then the block returns to IDLE.
- Back-to-back: vector A accepted, vector B accepted during A's RUN, ch0=0 in both -> RUN 16, GAP 1, RUN 16; gamma_start pulses 17 ticks apart; ch0 shows 1,0,1 across GAP (a fresh rising edge).
- Backpressure: shadow full and in_valid held with vector C during RUN -> in_ready=0, shadow not overwritten; C is accepted the tick after the next load, and C's values appear in the following cycle.
- Enable control:
  - enable=0 with shadow full -> stays IDLE indefinitely.
  - Then enable=1 -> RUN starts next tick.
  - Dropping enable at phase 4 -> RUN completes to phase 15, GAP, then IDLE even though the shadow is full.
- Reset mid-operation: grst asserted at phase 7 with the shadow full -> the next tick shows IDLE, spike_lines=0, phase=0, in_ready=1; no later gamma_start occurs until new data arrives.
